// File: rtl/dffq_chain_bist.sv
// BIST engine for an external chain of DEPTH D->Q flops: launches a PRBS-16 stream into the
// chain head and checks the tail against a delayed copy of what was launched.
module dffq_chain_bist #(
  parameter int unsigned DEPTH = 8,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned ERR_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [15:0]      LEN,
  output logic             CHAIN_D,
  input  logic             CHAIN_Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [15:0]      FIRST_FAIL
);

  localparam logic [15:0] DepthM1 = 16'(DEPTH - 1);
  localparam logic [15:0] NoFail  = 16'hFFFF;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               chain_d_q, chain_d_d;
  logic [DEPTH-1:0]   exp_q;
  logic [DEPTH-1:0]   vld_q;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [15:0]        ff_q, ff_d;
  logic [15:0]        idx_q, idx_d;
  logic               pass_q, pass_d;

  logic busy;
  logic start_ok;
  logic cmp_en;
  logic mism;
  logic lfsr_fb;

  assign busy     = (state_q == StFlush) || (state_q == StRun) || (state_q == StDrain);
  assign start_ok = START && ((state_q == StIdle) || (state_q == StDone));
  assign cmp_en   = busy && vld_q[DEPTH-1];
  assign mism     = cmp_en && (CHAIN_Q != exp_q[DEPTH-1]);

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    lfsr_d    = lfsr_q;
    err_d     = err_q;
    ff_d      = ff_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    chain_d_d = 1'b0;

    // Compare bookkeeping; idx counts valid compares, i.e. the pattern index of the tail bit.
    if (cmp_en) begin
      idx_d = idx_q + 16'd1;
      if (mism) begin
        if (err_q != '1) begin
          err_d = err_q + ERR_W'(1);
        end
        if (ff_q == NoFail) begin
          ff_d = idx_q;
        end
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (START) begin
          lfsr_d = SEED;
          err_d  = '0;
          ff_d   = NoFail;
          idx_d  = '0;
          len_d  = LEN;
          if (LEN == 16'd0) begin
            state_d = StDone;
            pass_d  = 1'b1;
          end else begin
            state_d = StFlush;
            cnt_d   = DepthM1;
            pass_d  = 1'b0;
          end
        end
      end
      StFlush: begin
        if (cnt_q == 16'd0) begin
          state_d = StRun;
          cnt_d   = len_q - 16'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StRun: begin
        if (cnt_q == 16'd0) begin
          state_d = StDrain;
          cnt_d   = DepthM1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StDrain: begin
        if (cnt_q == 16'd0) begin
          state_d = StDone;
          pass_d  = (err_d == '0);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // CHAIN_D is registered, so the bit for the next RUN cycle is picked one edge early.
    if (state_d == StRun) begin
      chain_d_d = lfsr_q[0];
      lfsr_d    = {lfsr_fb, lfsr_q[15:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      lfsr_q    <= SEED;
      chain_d_q <= 1'b0;
      exp_q     <= '0;
      vld_q     <= '0;
      err_q     <= '0;
      ff_q      <= NoFail;
      idx_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      lfsr_q    <= lfsr_d;
      chain_d_q <= chain_d_d;
      err_q     <= err_d;
      ff_q      <= ff_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      if (busy) begin
        for (int unsigned i = 1; i < DEPTH; i++) begin
          exp_q[i] <= exp_q[i-1];
          vld_q[i] <= vld_q[i-1];
        end
        exp_q[0] <= chain_d_q;
        vld_q[0] <= (state_q == StRun);
      end else if (start_ok) begin
        vld_q <= '0;
      end
    end
  end

  assign CHAIN_D    = chain_d_q;
  assign BUSY       = busy;
  assign DONE       = (state_q == StDone);
  assign PASS       = pass_q;
  assign ERR_CNT    = err_q;
  assign FIRST_FAIL = ff_q;

endmodule

// File: tb/tb_dffq_chain_bist.sv
// Bench for dffq_chain_bist: flop-chain model with fault modes, result scoreboard popped on DONE.
module tb_dffq_chain_bist;

  localparam int unsigned DEPTH = 8;
  localparam int MaxLen = 1000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] LEN = 16'd0;
  logic        CHAIN_D;
  logic        CHAIN_Q;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [7:0]  ERR_CNT;
  logic [15:0] FIRST_FAIL;

  dffq_chain_bist #(
    .DEPTH(DEPTH),
    .SEED (16'hACE1),
    .ERR_W(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .LEN       (LEN),
    .CHAIN_D   (CHAIN_D),
    .CHAIN_Q   (CHAIN_Q),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .PASS      (PASS),
    .ERR_CNT   (ERR_CNT),
    .FIRST_FAIL(FIRST_FAIL)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference PRBS stream, built straight from the polynomial.
  logic pat[MaxLen];
  initial begin
    logic [15:0] s;
    s = 16'hACE1;
    for (int i = 0; i < MaxLen; i++) begin
      pat[i] = s[0];
      s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end
  end

  // Chain model. Mode 0 ideal, 1 flips pattern bit 37, 2 tail stuck-at-0, 3 one stage short.
  int busy_cnt = 0;
  int mode = 0;
  logic [DEPTH-1:0] st = '0;
  logic flip;
  assign flip = (mode == 1) && BUSY && (busy_cnt == int'(DEPTH) + 38);
  always @(posedge CLK) st <= {st[DEPTH-2:0], CHAIN_D ^ flip};
  assign CHAIN_Q = (mode == 2) ? 1'b0 : (mode == 3) ? st[DEPTH-2] : st[DEPTH-1];

  typedef struct {
    int          len;
    int          busy;
    int          pass;
    int          err;
    int          ff;
  } exp_t;
  exp_t sb[$];

  int   stream_err = 0;
  int   done_events = 0;
  logic done_prev = 1'b0;

  // Monitor: checks the launched stream every busy cycle and pops a result on each DONE rise.
  always @(negedge CLK) begin
    if (RST) begin
      busy_cnt   = 0;
      stream_err = 0;
      done_prev  = 1'b0;
    end else begin
      if (BUSY) begin
        if (sb.size() > 0) begin
          logic e;
          e = 1'b0;
          if (busy_cnt >= int'(DEPTH) && busy_cnt < int'(DEPTH) + sb[0].len)
            e = pat[busy_cnt - int'(DEPTH)];
          if (CHAIN_D !== e) stream_err++;
        end
        busy_cnt++;
      end
      if (DONE && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("busy_cycles", busy_cnt, e.busy);
          chk("pass", int'(PASS), e.pass);
          chk("err_cnt", int'(ERR_CNT), e.err);
          chk("first_fail", int'(FIRST_FAIL), e.ff);
          chk("stream_errors", stream_err, 0);
        end
        busy_cnt   = 0;
        stream_err = 0;
        done_events++;
      end
      done_prev = DONE;
    end
  end

  task automatic start_run(input int len, input int m, input int p, input int e, input int f);
    exp_t x;
    @(negedge CLK);
    mode  = m;
    START = 1'b1;
    LEN   = 16'(len);
    x.len = len;
    x.busy = (len == 0) ? 0 : 2 * int'(DEPTH) + len;
    x.pass = p;
    x.err  = e;
    x.ff   = f;
    sb.push_back(x);
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int len);
    int n;
    bit seen;
    n = done_events;
    seen = 0;
    for (int c = 0; c < 2 * int'(DEPTH) + len + 20; c++) begin
      @(posedge CLK);
      if (done_events != n) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_chain_d"}, int'(CHAIN_D), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_done"}, int'(DONE), 0);
    chk({tag, "_pass"}, int'(PASS), 0);
    chk({tag, "_err"}, int'(ERR_CNT), 0);
    chk({tag, "_ff"}, int'(FIRST_FAIL), 16'hFFFF);
  endtask

  initial begin
    int short_err;
    int short_ff;
    int ones;
    #1;
    short_err = 0;
    short_ff  = 16'hFFFF;
    for (int i = 0; i < 100; i++) begin
      logic nxt;
      nxt = (i + 1 < 100) ? pat[i+1] : 1'b0;
      if (pat[i] != nxt) begin
        if (short_err < 255) short_err++;
        if (short_ff == 16'hFFFF) short_ff = i;
      end
    end
    ones = 0;
    for (int i = 0; i < 1000; i++) if (pat[i]) ones++;

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_reset_vals("rst0");

    start_run(100, 0, 1, 0, 16'hFFFF);
    wait_done(100);
    start_run(100, 1, 0, 1, 37);
    wait_done(100);
    // SEED bit 0 is 1, so the first launched bit already fails against a stuck-at-0 tail.
    start_run(1000, 2, 0, 255, 0);
    wait_done(1000);
    chk("stuck_ones_exceed_sat", int'(ones > 255), 1);

    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    start_run(0, 0, 1, 0, 16'hFFFF);
    wait_done(0);
    chk("len0_done_held", int'(DONE), 1);

    // Abandon a run mid-RUN with reset.
    start_run(100, 0, 1, 0, 16'hFFFF);
    for (int c = 0; c < 200 && busy_cnt < int'(DEPTH) + 50; c++) @(posedge CLK);
    chk("reached_mid_run", int'(busy_cnt >= int'(DEPTH) + 50), 1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk_reset_vals("rst_mid");
    sb.delete();
    RST = 1'b0;
    start_run(100, 0, 1, 0, 16'hFFFF);
    wait_done(100);

    // Short chain, with START pulses during BUSY that must be ignored.
    chk("short_ff_hand", short_ff, 0);
    for (int r = 0; r < 2; r++) begin
      start_run(100, 3, 0, short_err, short_ff);
      repeat (20) @(negedge CLK);
      chk("busy_mid", int'(BUSY), 1);
      chk("pass_low_busy", int'(PASS), 0);
      chk("done_low_busy", int'(DONE), 0);
      START = 1'b1;
      LEN   = 16'd5;
      @(negedge CLK);
      START = 1'b0;
      repeat (30) @(negedge CLK);
      START = 1'b1;
      LEN   = 16'd0;
      @(negedge CLK);
      START = 1'b0;
      wait_done(100);
    end
    chk("short_err_nonzero", int'(short_err > 0), 1);

    repeat (5) @(negedge CLK);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dffq_chain_bist.md
Name: dffq_chain_bist

Overview:
- Built-in self-test engine for a chain of DEPTH dffq cells clocked on CLK.
- Launches a PRBS bit stream into the chain head, captures the chain tail, and compares it against its own delayed copy of the launched stream.
- Reports mismatch count and first-failing bit index.
- Used on characterization test structures to confirm D->Q capture across a flop chain.

Parameters:
- DEPTH, 8, number of dffq stages in the external chain (1..64).
- SEED, 16'hACE1, nonzero LFSR reset/restart seed.
- ERR_W, 8, error counter width; counter saturates.

Ports:
- CLK  input  1  clock; rising edge; also clocks the external chain.
- RST  input  1  synchronous, active-high reset.
- START  input  1  single-cycle request; honoured in IDLE or DONE only.
- LEN  input  16  pattern length in bits; sampled when START is accepted.
- CHAIN_D  output  1  registered launch bit to chain stage 0 D.
- CHAIN_Q  input  1  Q of the last chain stage.
- BUSY  output  1  high in FLUSH/RUN/DRAIN.
- DONE  output  1  high in DONE state; results stable.
- PASS  output  1  valid when DONE=1; equals (ERR_CNT==0).
- ERR_CNT  output  ERR_W  saturating mismatch count.
- FIRST_FAIL  output  16  0-based pattern index of first mismatch; 16'hFFFF if none.

Behaviour:
- Reset (RST=1 at an edge), from any state:
  - FSM returns to IDLE.
  - CHAIN_D=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FIRST_FAIL=16'hFFFF.
  - LFSR=SEED; expected and valid shift registers cleared.
  - An in-flight test is abandoned and no result is retained.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. Shifts once per RUN cycle. The launch bit is LFSR bit 0.
- Chain timing contract: a value driven on CHAIN_D in cycle k is present on CHAIN_Q in cycle k+DEPTH.
- Internal tracking:
  - DEPTH-deep shift registers exp[] and vld[] advance every cycle in FLUSH/RUN/DRAIN.
  - exp[] is loaded with CHAIN_D. vld[] is loaded with 1 in RUN and 0 otherwise.
  - In cycle k, CHAIN_Q is compared only when vld[DEPTH-1]=1, against exp[DEPTH-1].
- FSM:
  - IDLE: START & LEN!=0 -> FLUSH. START & LEN==0 -> DONE with PASS=1, ERR_CNT=0, FIRST_FAIL=FFFF.
  - FLUSH: CHAIN_D=0 for DEPTH cycles, clearing the chain; no comparisons; then -> RUN.
  - RUN: drives LEN LFSR bits, indices 0..LEN-1; then -> DRAIN.
  - DRAIN: CHAIN_D=0 for DEPTH cycles while the last RUN bits are compared; then -> DONE.
  - DONE: DONE=1, results held. START -> same as IDLE handling.
- Start handling:
  - Accepting START reseeds the LFSR to SEED, clears ERR_CNT, and sets FIRST_FAIL=FFFF, so every run launches an identical stream.
  - START during BUSY is ignored.
- Latency: BUSY is high for exactly 2*DEPTH+LEN cycles, starting the cycle after START is sampled. DONE rises on the following cycle.
- Mismatch handling:
  - Each mismatch increments ERR_CNT, saturating at 2^ERR_W-1.
  - FIRST_FAIL is written only while it holds 16'hFFFF, with the pattern index of the compared bit. That index is tracked as a separate counter of valid compares.
- Output timing: PASS updates only on entry to DONE and is 0 outside DONE.
- LEN=16'hFFFF is legal. FIRST_FAIL=FFFF is then ambiguous only for index 65535; this is accepted.

Test Plan:
- Ideal chain model (DEPTH=8 shift register), LEN=100, START -> BUSY high 116 cycles; DONE=1, PASS=1, ERR_CNT=0, FIRST_FAIL=16'hFFFF.
- Model inverts the bit at pattern index 37 only, LEN=100 -> ERR_CNT=1, FIRST_FAIL=37, PASS=0.
- Chain tail stuck-at-0, LEN=1000 -> ERR_CNT=255 (saturated), FIRST_FAIL = index of the first LFSR 1-bit, PASS=0.
- LEN=0, START -> DONE=1 the next cycle, PASS=1, BUSY never high.
- RST asserted mid-RUN (cycle 50 of LEN=100), then START with LEN=100 on the ideal chain -> reset values observed; new run passes with a stream bit-identical to the first run.
- START pulses during BUSY ignored; chain model with DEPTH-1 stages -> ERR_CNT>0 and PASS=0; restart from DONE reproduces the same results.
